mp_booth_fifo: RTL and testbench

Parametrised, queued Booth multiplier. Operand pairs are written into an input FIFO. A radix-2 Booth engine takes one pair at a time, computes the exact double-width product in N steps, and pushes it into a result FIFO read by the host. It is the next-generation drop-in for the fixed 16-bit queued multiplier and sits on the host data bus. It adds configurable width and depth, a separate read/write handshake, a busy indication, a sticky error flag and optional unsigned mode.

---
 rtl/mp_booth_pkg.sv | 32 +++
 rtl/booth_sync_fifo.sv | 90 +++++++++
 rtl/mp_booth_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_mp_booth_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_booth_pkg.sv
// -----------------------------------------------------------------------------
// mp_booth_pkg
// Shared definitions for the queued Booth multiplier (mp_booth_fifo):
//   - state_t        : engine FSM states (S_IDLE, S_RUN, S_DONE)
//   - DEFAULT_WIDTH  : default operand width
//   - DEFAULT_DEPTH  : default entries per FIFO
//   - clog2()        : elaboration-time ceil(log2), used to size the step
//                      counter as clog2(WIDTH+2)
// -----------------------------------------------------------------------------
package mp_booth_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/booth_sync_fifo.sv
// -----------------------------------------------------------------------------
// booth_sync_fifo
// Single-clock FIFO with first-word fall-through output and registered
// empty/full flags.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, din   : write request and data (ignored while full)
//   pop         : read request (ignored while empty)
//   dout        : head entry, forced to 0 while empty
//   empty, full : registered occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module booth_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          push_ok;
  logic          pop_ok;

  // Requests are qualified against the registered flags, so a push into a
  // full FIFO is dropped even if a pop happens on the same edge.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == CW'(0));
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset; stale words are never visible because the
  // output is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/mp_booth_fifo.sv
// -----------------------------------------------------------------------------
// mp_booth_fifo
// Queued radix-2 Booth multiplier. Operand pairs enter an input FIFO, a
// sequential Booth engine computes one exact 2*WIDTH product at a time and
// pushes it into a result FIFO read by the host.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en        : push {op_a, op_b[, sign_mode]} into the input FIFO
//   op_a, op_b   : multiplicand, multiplier
//   sign_mode    : 1 = signed, 0 = unsigned (only with MP_BOOTH_UNSIGNED_EN)
//   rd_en        : pop the head of the result FIFO
//   data_output  : result FIFO head (fall-through), 0 while empty
//   e_flag       : result FIFO empty
//   f_flag       : input FIFO full
//   busy         : engine not idle
//   err_flag     : sticky; write while full or read while empty
// Optional feature macro: MP_BOOTH_UNSIGNED_EN (adds sign_mode / unsigned).
// -----------------------------------------------------------------------------
module mp_booth_fifo
  import mp_booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
`ifdef MP_BOOTH_UNSIGNED_EN
  input  logic               sign_mode,
`endif
  input  logic               rd_en,
  output logic [2*WIDTH-1:0] data_output,
  output logic               e_flag,
  output logic               f_flag,
  output logic               busy,
  output logic               err_flag
);

`ifdef MP_BOOTH_UNSIGNED_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif
  // acc carries one guard bit (two with unsigned support) so that adding or
  // subtracting the most negative / largest operand cannot overflow.
  localparam int AW = WIDTH + 1 + EXT;
  localparam int QW = WIDTH + EXT;
  localparam int IW = 2 * WIDTH + EXT;
  localparam int PW = 2 * WIDTH;
  localparam int CW = clog2(WIDTH + 2);

  logic [IW-1:0]    in_din, in_dout;
  logic             in_empty, in_full, in_pop;
  logic [PW-1:0]    res_din;
  logic             res_empty, res_full, res_push, res_pop;

  logic [WIDTH-1:0] in_a, in_b;
  logic             in_sign;
  logic [AW-1:0]    m_load;
  logic [QW-1:0]    q_load;
  logic [CW-1:0]    cnt_load;
  logic [AW-1:0]    sum;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    m_q, m_d;
  logic [QW-1:0]    q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
`ifdef MP_BOOTH_UNSIGNED_EN
  logic             signed_q, signed_d;
`endif

`ifdef MP_BOOTH_UNSIGNED_EN
  assign in_din = {sign_mode, op_a, op_b};
  assign {in_sign, in_a, in_b} = in_dout;
  // Signed operands are sign-extended into the spare bit; unsigned ones are
  // zero-extended so Booth sees them as positive (WIDTH+1)-bit numbers.
  assign q_load   = {in_b[WIDTH-1] & in_sign, in_b};
  assign cnt_load = in_sign ? CW'(WIDTH) : CW'(WIDTH + 1);
`else
  assign in_din = {op_a, op_b};
  assign {in_a, in_b} = in_dout;
  assign in_sign  = 1'b1;
  assign q_load   = in_b;
  assign cnt_load = CW'(WIDTH);
`endif
  assign m_load = {{(AW - WIDTH){in_a[WIDTH-1] & in_sign}}, in_a};

  booth_sync_fifo #(.DW(IW), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (wr_en),
    .din   (in_din),
    .pop   (in_pop),
    .dout  (in_dout),
    .empty (in_empty),
    .full  (in_full)
  );

  booth_sync_fifo #(.DW(PW), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (res_push),
    .din   (res_din),
    .pop   (res_pop),
    .dout  (data_output),
    .empty (res_empty),
    .full  (res_full)
  );

  assign res_pop = rd_en && !res_empty;

  // Booth recoding of the current multiplier bit pair.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  // Product alignment: in signed mode with the widened q register only WIDTH
  // steps run, so one unprocessed multiplier bit remains at q[0].
`ifdef MP_BOOTH_UNSIGNED_EN
  assign res_din = signed_q ? PW'({acc_q, q_q} >> 1) : PW'({acc_q, q_q});
`else
  assign res_din = PW'({acc_q, q_q});
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    m_d      = m_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    in_pop   = 1'b0;
    res_push = 1'b0;
`ifdef MP_BOOTH_UNSIGNED_EN
    signed_d = signed_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Starting only when the result FIFO has room guarantees DONE can
        // always push without stalling.
        if (!in_empty && !res_full) begin
          in_pop  = 1'b1;
          acc_d   = '0;
          m_d     = m_load;
          q_d     = q_load;
          qm1_d   = 1'b0;
          cnt_d   = cnt_load;
`ifdef MP_BOOTH_UNSIGNED_EN
          signed_d = in_sign;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = {sum[AW-1], sum[AW-1:1]};
        q_d   = {sum[0], q_q[QW-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_push = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_d = err_q | (wr_en & in_full) | (rd_en & res_empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifdef MP_BOOTH_UNSIGNED_EN
      signed_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`ifdef MP_BOOTH_UNSIGNED_EN
      signed_q <= signed_d;
`endif
    end
  end

  assign e_flag   = res_empty;
  assign f_flag   = in_full;
  assign busy     = (state_q != S_IDLE);
  assign err_flag = err_q;

endmodule

// File: tb/tb_mp_booth_fifo.sv
// -----------------------------------------------------------------------------
// tb_mp_booth_fifo
// Directed self-checking bench for mp_booth_fifo (WIDTH=16, DEPTH=8).
// Unsigned-mode scenarios are included when MP_BOOTH_UNSIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_mp_booth_fifo;

  localparam int W        = 16;
  localparam int D        = 8;
  localparam int N_SIGNED = 16;

  logic          clk;
  logic          reset_n;
  logic          wr_en;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          sign_mode;
  logic          rd_en;
  logic [2*W-1:0] data_output;
  logic          e_flag;
  logic          f_flag;
  logic          busy;
  logic          err_flag;

  int checks;
  int errors;

  mp_booth_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .op_a        (op_a),
    .op_b        (op_b),
`ifdef MP_BOOTH_UNSIGNED_EN
    .sign_mode   (sign_mode),
`endif
    .rd_en       (rd_en),
    .data_output (data_output),
    .e_flag      (e_flag),
    .f_flag      (f_flag),
    .busy        (busy),
    .err_flag    (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sm);
    wr_en     = 1'b1;
    op_a      = a;
    op_b      = b;
    sign_mode = sm;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_result();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_result(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (e_flag === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: e_flag=%b after %0d cycles, required 0",
               tag, e_flag, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (data_output !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 00000000", data_output); end
    checks++; if (e_flag !== 1'b1) begin errors++; $display("[TB] FAIL reset_e_flag: got %b want 1", e_flag); end
    checks++; if (f_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_f_flag: got %b want 0", f_flag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err_flag); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_signed();
    push_pair(16'd3, 16'hFFFB, 1'b1);
    for (int i = 0; i < N_SIGNED + 1; i++) tick();
    checks++; if (e_flag !== 1'b1) begin errors++; $display("[TB] FAIL signed_early_empty: got %b want 1", e_flag); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL signed_busy: got %b want 1", busy); end
    tick();
    checks++; if (e_flag !== 1'b0) begin errors++; $display("[TB] FAIL signed_ready: got %b want 0", e_flag); end
    checks++; if (data_output !== 32'hFFFF_FFF1) begin errors++; $display("[TB] FAIL signed_product: got %h want FFFFFFF1", data_output); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL signed_idle: got %b want 0", busy); end
    pop_result();
    checks++; if (e_flag !== 1'b1) begin errors++; $display("[TB] FAIL signed_pop_empty: got %b want 1", e_flag); end
    checks++; if (data_output !== 32'h0) begin errors++; $display("[TB] FAIL signed_pop_data: got %h want 00000000", data_output); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("[TB] FAIL signed_err: got %b want 0", err_flag); end
  endtask

  task automatic test_corner();
    push_pair(16'h8000, 16'h8000, 1'b1);
    push_pair(16'h7FFF, 16'h8000, 1'b1);
    wait_result(60, "corner_min_min");
    checks++; if (data_output !== 32'h4000_0000) begin errors++; $display("[TB] FAIL corner_min_min: got %h want 40000000", data_output); end
    pop_result();
    wait_result(60, "corner_max_min");
    checks++; if (data_output !== 32'hC000_8000) begin errors++; $display("[TB] FAIL corner_max_min: got %h want C0008000", data_output); end
    pop_result();
    checks++; if (e_flag !== 1'b1) begin errors++; $display("[TB] FAIL corner_drained: got %b want 1", e_flag); end
  endtask

  task automatic test_empty_read();
    pop_result();
    checks++; if (err_flag !== 1'b1) begin errors++; $display("[TB] FAIL empty_read_err: got %b want 1", err_flag); end
    checks++; if (data_output !== 32'h0) begin errors++; $display("[TB] FAIL empty_read_data: got %h want 00000000", data_output); end
    checks++; if (e_flag !== 1'b1) begin errors++; $display("[TB] FAIL empty_read_e_flag: got %b want 1", e_flag); end
    checks++; if (f_flag !== 1'b0) begin errors++; $display("[TB] FAIL empty_read_f_flag: got %b want 0", f_flag); end
  endtask

  task automatic test_reset_mid_run();
    push_pair(16'd7, 16'd9, 1'b1);
    tick();
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy_before: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_busy: got %b want 0", busy); end
    checks++; if (e_flag !== 1'b1) begin errors++; $display("[TB] FAIL midrun_e_flag: got %b want 1", e_flag); end
    checks++; if (f_flag !== 1'b0) begin errors++; $display("[TB] FAIL midrun_f_flag: got %b want 0", f_flag); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("[TB] FAIL midrun_err: got %b want 0", err_flag); end
    tick();
    reset_n = 1'b1;
    tick();
    push_pair(16'd2, 16'd6, 1'b1);
    wait_result(60, "midrun_new");
    checks++; if (data_output !== 32'h0000_000C) begin errors++; $display("[TB] FAIL midrun_new_product: got %h want 0000000C", data_output); end
    pop_result();
    for (int i = 0; i < 25; i++) tick();
    checks++; if (e_flag !== 1'b1) begin errors++; $display("[TB] FAIL midrun_no_stale: got %b want 1", e_flag); end
  endtask

  task automatic test_full();
    logic [2*W-1:0] expected [2*D];
    shortint sa;
    shortint sb;
    apply_reset();
    for (int i = 0; i <= 2 * D; i++) begin
      sa = shortint'(i + 1);
      sb = shortint'(i * 3 - 20);
      if (i < 2 * D) expected[i] = 32'(int'(sa) * int'(sb));
    end
    for (int i = 0; i < D; i++) begin
      push_pair(W'(i + 1), W'(i * 3 - 20), 1'b1);
    end
    for (int i = 0; i < D * (N_SIGNED + 3) + 20; i++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_stalled: busy got %b want 0", busy); end
    checks++; if (e_flag !== 1'b0) begin errors++; $display("[TB] FAIL full_results_held: e_flag got %b want 0", e_flag); end
    for (int i = D; i < 2 * D; i++) begin
      push_pair(W'(i + 1), W'(i * 3 - 20), 1'b1);
      if (i == 2 * D - 2) begin
        checks++; if (f_flag !== 1'b0) begin errors++; $display("[TB] FAIL full_flag_early: got %b want 0", f_flag); end
      end
    end
    checks++; if (f_flag !== 1'b1) begin errors++; $display("[TB] FAIL full_flag_set: got %b want 1", f_flag); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("[TB] FAIL full_err_before: got %b want 0", err_flag); end
    push_pair(W'(2 * D + 1), W'(2 * D * 3 - 20), 1'b1);
    checks++; if (err_flag !== 1'b1) begin errors++; $display("[TB] FAIL full_err_after: got %b want 1", err_flag); end
    checks++; if (f_flag !== 1'b1) begin errors++; $display("[TB] FAIL full_flag_hold: got %b want 1", f_flag); end
    for (int i = 0; i < 2 * D; i++) begin
      wait_result(60, "full_drain");
      checks++;
      if (data_output !== expected[i]) begin
        errors++;
        $display("[TB] FAIL full_drain_%0d: got %h want %h", i, data_output, expected[i]);
      end
      pop_result();
    end
    for (int i = 0; i < 25; i++) tick();
    checks++; if (e_flag !== 1'b1) begin errors++; $display("[TB] FAIL full_drained_empty: got %b want 1", e_flag); end
    checks++; if (f_flag !== 1'b0) begin errors++; $display("[TB] FAIL full_drained_f_flag: got %b want 0", f_flag); end
  endtask

`ifdef MP_BOOTH_UNSIGNED_EN
  task automatic test_unsigned();
    apply_reset();
    push_pair(16'hFFFF, 16'hFFFF, 1'b0);
    push_pair(16'hFFFF, 16'hFFFF, 1'b1);
    wait_result(60, "unsigned");
    checks++; if (data_output !== 32'hFFFE_0001) begin errors++; $display("[TB] FAIL unsigned_product: got %h want FFFE0001", data_output); end
    pop_result();
    wait_result(60, "unsigned_signed");
    checks++; if (data_output !== 32'h0000_0001) begin errors++; $display("[TB] FAIL unsigned_signed_product: got %h want 00000001", data_output); end
    pop_result();
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b1;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sign_mode = 1'b1;
    #2;
    test_reset();
    test_signed();
    test_corner();
    test_empty_read();
    test_reset_mid_run();
    test_full();
`ifdef MP_BOOTH_UNSIGNED_EN
    test_unsigned();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
